// File: rtl/machine_mode_types_1_12_pkg.sv
// rtl/machine_mode_types_1_12_pkg.sv - shared types and constants for machine-mode trap sequencing
// Purpose: sequencer state encoding, mcause codes, mtvec mode encoding, mtvec base helper.
// Ports: none (package).
package machine_mode_types_1_12_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_state_t;

  // Exception codes (mcause[31] = 0)
  localparam logic [30:0] EXC_INSN_MISALIGN  = 31'd0;
  localparam logic [30:0] EXC_INSN_FAULT     = 31'd1;
  localparam logic [30:0] EXC_ILLEGAL_INSN   = 31'd2;
  localparam logic [30:0] EXC_BREAKPOINT     = 31'd3;
  localparam logic [30:0] EXC_LOAD_MISALIGN  = 31'd4;
  localparam logic [30:0] EXC_LOAD_FAULT     = 31'd5;
  localparam logic [30:0] EXC_STORE_MISALIGN = 31'd6;
  localparam logic [30:0] EXC_STORE_FAULT    = 31'd7;
  localparam logic [30:0] EXC_ECALL_M        = 31'd11;

  // Interrupt codes (mcause[31] = 1)
  localparam logic [30:0] INT_SOFT_M  = 31'd3;
  localparam logic [30:0] INT_TIMER_M = 31'd7;
  localparam logic [30:0] INT_EXT_M   = 31'd11;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'b00,
    MTVEC_VECTORED = 2'b01
  } mtvec_mode_t;

  function automatic logic [31:0] mtvec_base(input logic [31:0] mtvec);
    return {mtvec[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/priv_trap_sequencer_if.sv
// rtl/priv_trap_sequencer_if.sv - event/CSR/redirect bundle between hazard unit, CSR file and trap sequencer
// Purpose: groups all non-clock signals of priv_trap_sequencer.
// Ports (signals): exception strobes, PMP faults, RISC-MGMT exception, ret, interrupt lines
//   and enables, epc/badaddr/mtvec/mepc_r, pipe_clear (into sequencer); insert_pc/priv_pc,
//   intr, busy, csr_trap_we/csr_ret_we, mepc/mcause/mtval write data (out of sequencer).
// master: environment side (hazard unit + CSR file); slave: the sequencer.
interface priv_trap_sequencer_if #(
  parameter int RMGMT_CAUSE_W = 2
);
  logic                     fault_insn, mal_insn, illegal_insn;
  logic                     fault_l, mal_l, fault_s, mal_s;
  logic                     breakpoint, env_m;
  logic                     prot_fault_i, prot_fault_l, prot_fault_s;
  logic                     ex_rmgmt;
  logic [RMGMT_CAUSE_W-1:0] ex_rmgmt_cause;
  logic                     ret;
  logic                     timer_int, soft_int, ext_int;
  logic                     mie_mtie, mie_msie, mie_meie, mstatus_mie;
  logic [31:0]              epc, badaddr, mtvec, mepc_r;
  logic                     pipe_clear;
  logic                     insert_pc;
  logic [31:0]              priv_pc;
  logic                     intr, busy;
  logic                     csr_trap_we, csr_ret_we;
  logic [31:0]              mepc_wdata, mtval_wdata, mcause_wdata;

  modport master (
    output fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
           breakpoint, env_m, prot_fault_i, prot_fault_l, prot_fault_s,
           ex_rmgmt, ex_rmgmt_cause, ret, timer_int, soft_int, ext_int,
           mie_mtie, mie_msie, mie_meie, mstatus_mie,
           epc, badaddr, mtvec, mepc_r, pipe_clear,
    input  insert_pc, priv_pc, intr, busy, csr_trap_we, csr_ret_we,
           mepc_wdata, mtval_wdata, mcause_wdata
  );

  modport slave (
    input  fault_insn, mal_insn, illegal_insn, fault_l, mal_l, fault_s, mal_s,
           breakpoint, env_m, prot_fault_i, prot_fault_l, prot_fault_s,
           ex_rmgmt, ex_rmgmt_cause, ret, timer_int, soft_int, ext_int,
           mie_mtie, mie_msie, mie_meie, mstatus_mie,
           epc, badaddr, mtvec, mepc_r, pipe_clear,
    output insert_pc, priv_pc, intr, busy, csr_trap_we, csr_ret_we,
           mepc_wdata, mtval_wdata, mcause_wdata
  );
endinterface

// File: rtl/priv_cause_prio.sv
// rtl/priv_cause_prio.sv - fixed-priority encoder for trap/return events
// Purpose: picks the single winning event of a cycle.
// Ports: exception/ret/interrupt strobes and enables in; valid, is_intr, is_ret,
//   cause (31-bit code), tval_sel (1 = mtval takes badaddr) out. Purely combinational.
module priv_cause_prio
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int RMGMT_CAUSE_W    = 2,
  parameter int RMGMT_CAUSE_BASE = 24
) (
  input  logic                     fault_insn,
  input  logic                     mal_insn,
  input  logic                     illegal_insn,
  input  logic                     fault_l,
  input  logic                     mal_l,
  input  logic                     fault_s,
  input  logic                     mal_s,
  input  logic                     breakpoint,
  input  logic                     env_m,
  input  logic                     prot_fault_i,
  input  logic                     prot_fault_l,
  input  logic                     prot_fault_s,
  input  logic                     ex_rmgmt,
  input  logic [RMGMT_CAUSE_W-1:0] ex_rmgmt_cause,
  input  logic                     ret,
  input  logic                     timer_int,
  input  logic                     soft_int,
  input  logic                     ext_int,
  input  logic                     mie_mtie,
  input  logic                     mie_msie,
  input  logic                     mie_meie,
  input  logic                     mstatus_mie,
  output logic                     valid,
  output logic                     is_intr,
  output logic                     is_ret,
  output logic [30:0]              cause,
  output logic                     tval_sel
);

  logic any_fault_insn, any_fault_l, any_fault_s;
  logic ext_en, soft_en, timer_en;

  assign any_fault_insn = fault_insn | prot_fault_i;
  assign any_fault_l    = fault_l | prot_fault_l;
  assign any_fault_s    = fault_s | prot_fault_s;
  assign ext_en         = ext_int & mie_meie & mstatus_mie;
  assign soft_en        = soft_int & mie_msie & mstatus_mie;
  assign timer_en       = timer_int & mie_mtie & mstatus_mie;

  always_comb begin
    valid    = 1'b1;
    is_intr  = 1'b0;
    is_ret   = 1'b0;
    cause    = '0;
    tval_sel = 1'b0;
    if (breakpoint) begin
      cause = EXC_BREAKPOINT;
    end else if (any_fault_insn) begin
      cause = EXC_INSN_FAULT;     tval_sel = 1'b1;
    end else if (mal_insn) begin
      cause = EXC_INSN_MISALIGN;  tval_sel = 1'b1;
    end else if (illegal_insn) begin
      cause = EXC_ILLEGAL_INSN;
    end else if (env_m) begin
      cause = EXC_ECALL_M;
    end else if (ex_rmgmt) begin
      cause = 31'(RMGMT_CAUSE_BASE) + 31'(ex_rmgmt_cause);
    end else if (mal_s) begin
      cause = EXC_STORE_MISALIGN; tval_sel = 1'b1;
    end else if (mal_l) begin
      cause = EXC_LOAD_MISALIGN;  tval_sel = 1'b1;
    end else if (any_fault_s) begin
      cause = EXC_STORE_FAULT;    tval_sel = 1'b1;
    end else if (any_fault_l) begin
      cause = EXC_LOAD_FAULT;     tval_sel = 1'b1;
    end else if (ret) begin
      is_ret = 1'b1;
    end else if (ext_en) begin
      is_intr = 1'b1; cause = INT_EXT_M;
    end else if (soft_en) begin
      is_intr = 1'b1; cause = INT_SOFT_M;
    end else if (timer_en) begin
      is_intr = 1'b1; cause = INT_TIMER_M;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/priv_trap_sequencer.sv
// rtl/priv_trap_sequencer.sv - multi-cycle trap entry / mret sequencer for machine mode
// Purpose: latch the winning event in IDLE, wait for pipe_clear, pulse the CSR
//   trap/ret write, then redirect fetch to the trap vector or mepc.
// Ports: CLK, RST (async, active-high); bus (priv_trap_sequencer_if.slave) carrying
//   event strobes, CSR values, pipe_clear in and redirect/CSR-write signals out.
//   All outputs are registered.
module priv_trap_sequencer
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int NUM_EXTENSIONS   = 4,
  parameter int RMGMT_CAUSE_W    = $clog2(NUM_EXTENSIONS),
  parameter int RMGMT_CAUSE_BASE = 24
) (
  input logic                  CLK,
  input logic                  RST,
  priv_trap_sequencer_if.slave bus
);

  logic        prio_valid, prio_is_intr, prio_is_ret, prio_tval_sel;
  logic [30:0] prio_cause;

  priv_cause_prio #(
    .RMGMT_CAUSE_W   (RMGMT_CAUSE_W),
    .RMGMT_CAUSE_BASE(RMGMT_CAUSE_BASE)
  ) u_prio (
    .fault_insn    (bus.fault_insn),
    .mal_insn      (bus.mal_insn),
    .illegal_insn  (bus.illegal_insn),
    .fault_l       (bus.fault_l),
    .mal_l         (bus.mal_l),
    .fault_s       (bus.fault_s),
    .mal_s         (bus.mal_s),
    .breakpoint    (bus.breakpoint),
    .env_m         (bus.env_m),
    .prot_fault_i  (bus.prot_fault_i),
    .prot_fault_l  (bus.prot_fault_l),
    .prot_fault_s  (bus.prot_fault_s),
    .ex_rmgmt      (bus.ex_rmgmt),
    .ex_rmgmt_cause(bus.ex_rmgmt_cause),
    .ret           (bus.ret),
    .timer_int     (bus.timer_int),
    .soft_int      (bus.soft_int),
    .ext_int       (bus.ext_int),
    .mie_mtie      (bus.mie_mtie),
    .mie_msie      (bus.mie_msie),
    .mie_meie      (bus.mie_meie),
    .mstatus_mie   (bus.mstatus_mie),
    .valid         (prio_valid),
    .is_intr       (prio_is_intr),
    .is_ret        (prio_is_ret),
    .cause         (prio_cause),
    .tval_sel      (prio_tval_sel)
  );

  trap_state_t state_q, state_d;
  logic        is_intr_q, is_intr_d;
  logic        is_ret_q, is_ret_d;
  logic [30:0] cause_q, cause_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] epc_q, epc_d;
  logic        busy_q, busy_d;
  logic        intr_q, intr_d;
  logic        csr_trap_we_q, csr_trap_we_d;
  logic        csr_ret_we_q, csr_ret_we_d;
  logic        insert_pc_q, insert_pc_d;
  logic [31:0] priv_pc_q, priv_pc_d;
  logic [31:0] trap_target;

  // Vectored mode only applies to interrupts; exceptions always use the base.
  always_comb begin
    trap_target = mtvec_base(bus.mtvec);
    if ((bus.mtvec[1:0] == MTVEC_VECTORED) && is_intr_q) begin
      trap_target = mtvec_base(bus.mtvec) + {cause_q[29:0], 2'b00};
    end
  end

  always_comb begin
    state_d       = state_q;
    is_intr_d     = is_intr_q;
    is_ret_d      = is_ret_q;
    cause_d       = cause_q;
    tval_d        = tval_q;
    epc_d         = epc_q;
    priv_pc_d     = priv_pc_q;
    csr_trap_we_d = 1'b0;
    csr_ret_we_d  = 1'b0;
    insert_pc_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Event inputs are only looked at here; the latched copy carries the
        // trap through DRAIN even if the source line drops.
        if (prio_valid) begin
          state_d   = ST_DRAIN;
          is_intr_d = prio_is_intr;
          is_ret_d  = prio_is_ret;
          cause_d   = prio_cause;
          tval_d    = prio_tval_sel ? bus.badaddr : 32'd0;
          epc_d     = bus.epc;
        end
      end
      ST_DRAIN: begin
        if (bus.pipe_clear) begin
          state_d       = ST_COMMIT;
          csr_trap_we_d = ~is_ret_q;
          csr_ret_we_d  = is_ret_q;
        end
      end
      ST_COMMIT: begin
        // mepc_r is read here, before the CSR write issued this cycle lands.
        state_d     = ST_REDIRECT;
        insert_pc_d = 1'b1;
        priv_pc_d   = is_ret_q ? bus.mepc_r : trap_target;
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    intr_d = (state_d != ST_IDLE) & is_intr_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      is_intr_q     <= 1'b0;
      is_ret_q      <= 1'b0;
      cause_q       <= '0;
      tval_q        <= '0;
      epc_q         <= '0;
      busy_q        <= 1'b0;
      intr_q        <= 1'b0;
      csr_trap_we_q <= 1'b0;
      csr_ret_we_q  <= 1'b0;
      insert_pc_q   <= 1'b0;
      priv_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      is_intr_q     <= is_intr_d;
      is_ret_q      <= is_ret_d;
      cause_q       <= cause_d;
      tval_q        <= tval_d;
      epc_q         <= epc_d;
      busy_q        <= busy_d;
      intr_q        <= intr_d;
      csr_trap_we_q <= csr_trap_we_d;
      csr_ret_we_q  <= csr_ret_we_d;
      insert_pc_q   <= insert_pc_d;
      priv_pc_q     <= priv_pc_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.intr         = intr_q;
  assign bus.csr_trap_we  = csr_trap_we_q;
  assign bus.csr_ret_we   = csr_ret_we_q;
  assign bus.insert_pc    = insert_pc_q;
  assign bus.priv_pc      = priv_pc_q;
  assign bus.mepc_wdata   = epc_q;
  assign bus.mtval_wdata  = tval_q;
  assign bus.mcause_wdata = {is_intr_q, cause_q};

endmodule

// File: tb/tb_priv_trap_sequencer.sv
// tb/tb_priv_trap_sequencer.sv - self-checking bench for priv_trap_sequencer
module tb_priv_trap_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  priv_trap_sequencer_if #(.RMGMT_CAUSE_W(2)) bus ();

  priv_trap_sequencer #(.NUM_EXTENSIONS(4), .RMGMT_CAUSE_BASE(24)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  localparam int F_FI = 0,  F_MI = 1,  F_ILL = 2,  F_FL = 3,  F_ML = 4,  F_FS = 5,  F_MS = 6;
  localparam int F_BP = 7,  F_ENV = 8, F_PI = 9,   F_PL = 10, F_PS = 11, F_RM = 12, F_RET = 13;
  localparam int F_TI = 14, F_SI = 15, F_EI = 16,  F_MTIE = 17, F_MSIE = 18, F_MEIE = 19, F_MIE = 20;
  localparam logic [20:0] EN_MASK = 21'h1E0000;

  typedef struct {
    logic [20:0] f;
    logic [1:0]  idx;
    logic [31:0] epc, badaddr, mtvec, mepc_r;
    int          drain;
    logic        ev, is_ret, intr;
    logic [31:0] cause, tval, pc;
  } vec_t;

  int tests = 0;
  int fails = 0;

  function automatic logic [20:0] b(input int i);
    return 21'(1) << i;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [20:0] f, input logic [1:0] idx);
    bus.fault_insn   = f[F_FI];  bus.mal_insn     = f[F_MI];  bus.illegal_insn = f[F_ILL];
    bus.fault_l      = f[F_FL];  bus.mal_l        = f[F_ML];  bus.fault_s      = f[F_FS];
    bus.mal_s        = f[F_MS];  bus.breakpoint   = f[F_BP];  bus.env_m        = f[F_ENV];
    bus.prot_fault_i = f[F_PI];  bus.prot_fault_l = f[F_PL];  bus.prot_fault_s = f[F_PS];
    bus.ex_rmgmt     = f[F_RM];  bus.ex_rmgmt_cause = idx;    bus.ret          = f[F_RET];
    bus.timer_int    = f[F_TI];  bus.soft_int     = f[F_SI];  bus.ext_int      = f[F_EI];
    bus.mie_mtie     = f[F_MTIE]; bus.mie_msie    = f[F_MSIE]; bus.mie_meie    = f[F_MEIE];
    bus.mstatus_mie  = f[F_MIE];
  endtask

  function automatic vec_t mk(input logic [20:0] f, input logic [1:0] idx,
                              input logic [31:0] epc, input logic [31:0] bad,
                              input logic [31:0] mtvec, input logic [31:0] mepc_r,
                              input int drain, input logic ev, input logic is_ret,
                              input logic intr, input logic [31:0] cause,
                              input logic [31:0] tval, input logic [31:0] pc);
    vec_t v;
    v.f = f; v.idx = idx; v.epc = epc; v.badaddr = bad; v.mtvec = mtvec; v.mepc_r = mepc_r;
    v.drain = drain; v.ev = ev; v.is_ret = is_ret; v.intr = intr;
    v.cause = cause; v.tval = tval; v.pc = pc;
    return v;
  endfunction

  // Reference: walk the priority list, first active entry wins.
  function automatic vec_t model(input vec_t v);
    bit   act [14];
    int   code[14];
    int   k;
    logic [31:0] base;
    logic [20:0] f;
    f = v.f;
    act[0]  = f[F_BP];            code[0]  = 3;
    act[1]  = f[F_FI] | f[F_PI];  code[1]  = 1;
    act[2]  = f[F_MI];            code[2]  = 0;
    act[3]  = f[F_ILL];           code[3]  = 2;
    act[4]  = f[F_ENV];           code[4]  = 11;
    act[5]  = f[F_RM];            code[5]  = 24 + int'(v.idx);
    act[6]  = f[F_MS];            code[6]  = 6;
    act[7]  = f[F_ML];            code[7]  = 4;
    act[8]  = f[F_FS] | f[F_PS];  code[8]  = 7;
    act[9]  = f[F_FL] | f[F_PL];  code[9]  = 5;
    act[10] = f[F_RET];           code[10] = 0;
    act[11] = f[F_EI] & f[F_MEIE] & f[F_MIE]; code[11] = 11;
    act[12] = f[F_SI] & f[F_MSIE] & f[F_MIE]; code[12] = 3;
    act[13] = f[F_TI] & f[F_MTIE] & f[F_MIE]; code[13] = 7;
    k = -1;
    for (int i = 13; i >= 0; i--) if (act[i]) k = i;
    v.ev = (k >= 0);
    v.is_ret = (k == 10);
    v.intr = (k >= 11);
    v.cause = 0; v.tval = 0; v.pc = 0;
    if (k < 0) return v;
    v.cause = v.intr ? (32'h8000_0000 | 32'(code[k])) : 32'(code[k]);
    if (k < 10 && (code[k] inside {0, 1, 4, 5, 6, 7})) v.tval = v.badaddr;
    base = v.mtvec & ~32'd3;
    if (v.is_ret) v.pc = v.mepc_r;
    else if (v.intr && v.mtvec[1:0] == 2'b01) v.pc = base + 32'(4 * code[k]);
    else v.pc = base;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int   cyc;
    logic got;
    @(negedge clk);
    drive(v.f, v.idx);
    bus.epc = v.epc; bus.badaddr = v.badaddr; bus.mtvec = v.mtvec; bus.mepc_r = v.mepc_r;
    bus.pipe_clear = (v.drain == 0);
    @(negedge clk);
    drive(v.f & EN_MASK, 2'd0);
    if (!v.ev) begin
      chk({nm, " no-event busy"}, 32'(bus.busy), 0);
      chk({nm, " no-event pulses"}, 32'({bus.csr_trap_we, bus.csr_ret_we, bus.insert_pc}), 0);
      return;
    end
    chk({nm, " drain busy"}, 32'(bus.busy), 1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc <= v.drain + 4) begin
      if (cyc >= v.drain) bus.pipe_clear = 1'b1;
      @(negedge clk);
      cyc++;
      got = bus.csr_trap_we | bus.csr_ret_we;
    end
    chk({nm, " commit latency"}, 32'(cyc), 32'(v.drain + 1));
    if (!got) return;
    chk({nm, " trap_we"}, 32'(bus.csr_trap_we), 32'(!v.is_ret));
    chk({nm, " ret_we"}, 32'(bus.csr_ret_we), 32'(v.is_ret));
    chk({nm, " commit intr"}, 32'(bus.intr), 32'(v.intr));
    if (!v.is_ret) begin
      chk({nm, " mcause"}, bus.mcause_wdata, v.cause);
      chk({nm, " mtval"}, bus.mtval_wdata, v.tval);
      chk({nm, " mepc"}, bus.mepc_wdata, v.epc);
    end
    @(negedge clk);
    chk({nm, " insert_pc"}, 32'({bus.insert_pc, bus.busy, bus.csr_trap_we, bus.csr_ret_we}), 32'b1100);
    chk({nm, " priv_pc"}, bus.priv_pc, v.pc);
    chk({nm, " redirect intr"}, 32'(bus.intr), 32'(v.intr));
    @(negedge clk);
    chk({nm, " back idle"}, 32'({bus.insert_pc, bus.busy, bus.intr}), 0);
    bus.pipe_clear = 1'b0;
  endtask

  vec_t tbl[11];
  vec_t rv;
  logic [31:0] r;
  logic        seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(b(F_ILL), 0, 32'h200, 32'h0, 32'h100, 0, 0, 1, 0, 0, 2, 0, 32'h100);
    tbl[1]  = mk(b(F_FL) | b(F_TI) | b(F_MTIE) | b(F_MIE), 0, 32'h300, 32'hDEAD, 32'h100, 0, 1,
                 1, 0, 0, 5, 32'hDEAD, 32'h100);
    tbl[2]  = mk(b(F_EI) | b(F_SI) | b(F_MEIE) | b(F_MSIE) | b(F_MIE), 0, 32'h500, 32'h77, 32'h101, 0, 0,
                 1, 0, 1, 32'h8000_000B, 0, 32'h12C);
    tbl[3]  = mk(b(F_RET), 0, 0, 0, 32'h100, 32'h400, 4, 1, 1, 0, 0, 0, 32'h400);
    tbl[4]  = mk(b(F_TI) | b(F_MTIE), 0, 0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(b(F_BP) | b(F_FI), 0, 32'h40, 32'h55, 32'h180, 0, 0, 1, 0, 0, 3, 0, 32'h180);
    tbl[6]  = mk(b(F_PS), 0, 32'h44, 32'h44, 32'h101, 0, 2, 1, 0, 0, 7, 32'h44, 32'h100);
    tbl[7]  = mk(b(F_RM) | b(F_MS), 2, 32'h60, 32'h9, 32'h100, 0, 0, 1, 0, 0, 26, 0, 32'h100);
    tbl[8]  = mk(b(F_RET) | b(F_SI) | b(F_MSIE) | b(F_MIE), 0, 0, 0, 32'h100, 32'h880, 2,
                 1, 1, 0, 0, 0, 32'h880);
    tbl[9]  = mk(b(F_TI) | b(F_MTIE) | b(F_MIE), 0, 32'h70, 32'h1, 32'h201, 0, 3,
                 1, 0, 1, 32'h8000_0007, 0, 32'h21C);
    tbl[10] = mk(b(F_ML) | b(F_FS) | b(F_FL), 0, 32'h80, 32'hABC, 32'h100, 0, 0,
                 1, 0, 0, 4, 32'hABC, 32'h100);

    rst = 1'b1;
    drive('0, 2'd0);
    bus.epc = 0; bus.badaddr = 0; bus.mtvec = 0; bus.mepc_r = 0; bus.pipe_clear = 0;
    repeat (2) @(negedge clk);
    chk("reset outputs", 32'({bus.busy, bus.intr, bus.insert_pc, bus.csr_trap_we, bus.csr_ret_we}), 0);
    chk("reset priv_pc", bus.priv_pc, 0);
    chk("reset mcause", bus.mcause_wdata, 0);
    rst = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // mepc_r changes during DRAIN: the value present in COMMIT is the target.
    rv = mk(b(F_RET), 0, 0, 0, 32'h100, 32'h111, 2, 1, 1, 0, 0, 0, 32'h400);
    fork
      begin
        @(negedge clk); @(negedge clk); @(negedge clk);
        bus.mepc_r = 32'h400;
      end
      run_vec(rv, "mepc_late");
    join

    // Reset in the middle of DRAIN aborts without any CSR pulse.
    @(negedge clk);
    drive(b(F_ILL), 2'd0);
    bus.pipe_clear = 1'b0;
    @(negedge clk);
    drive('0, 2'd0);
    chk("rst-mid busy before", 32'(bus.busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst-mid outputs", 32'({bus.busy, bus.intr, bus.insert_pc, bus.csr_trap_we, bus.csr_ret_we}), 0);
    chk("rst-mid mcause", bus.mcause_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.pipe_clear = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bus.csr_trap_we | bus.csr_ret_we | bus.insert_pc | bus.busy;
    end
    chk("rst-mid no pulses after", 32'(seen), 0);
    bus.pipe_clear = 1'b0;

    for (int n = 0; n < 40; n++) begin
      rv.f = 21'($urandom & $urandom & $urandom) & ~EN_MASK;
      r = $urandom;
      rv.f[20:17] = r[3:0] | {r[4], 3'b000};
      if (r[5]) rv.f[13:0] = '0;
      rv.idx = r[7:6];
      rv.epc = $urandom;
      rv.badaddr = $urandom;
      r = $urandom;
      rv.mtvec = {r[31:2], 1'b0, r[0]};
      rv.mepc_r = $urandom;
      rv.drain = $urandom_range(0, 3);
      rv = model(rv);
      run_vec(rv, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
